// File: rtl/prog_cycle_counter.sv
`default_nettype none
// ==========================================================================
// prog_cycle_counter - CH independent one-shot/auto-reload cycle counters
// Rev 1.0
// ==========================================================================
module prog_cycle_counter #(
    parameter int W  = 4,
    parameter int CH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   abort,
    input  logic [CH-1:0]   hold,
    input  logic [CH-1:0]   reload,
    input  logic [CH*W-1:0] term,
    output logic [CH*W-1:0] count,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   done,
    output logic [CH-1:0]   tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t         r_state;
        logic [W-1:0]   r_count;
        logic [W-1:0]   r_term;
        logic           r_mode;
        logic           r_busy;
        logic           r_done;
        logic           r_tick;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_term  <= '0;
                r_mode  <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_tick  <= 1'b0;
            end else if (abort[i]) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_tick  <= 1'b0;
            end else if (start[i]) begin
                // Restart wins over a coincident terminal event.
                r_state <= S_RUN;
                r_count <= '0;
                r_term  <= term[i*W +: W];
                r_mode  <= reload[i];
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                case (r_state)
                    S_RUN: begin
                        if (!hold[i]) begin
                            if (r_count != r_term) begin
                                r_count <= r_count + W'(1);
                            end else begin
                                r_tick <= 1'b1;
                                if (r_mode) begin
                                    r_count <= '0;
                                end else begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign count[i*W +: W] = r_count;
        assign busy[i]         = r_busy;
        assign done[i]         = r_done;
        assign tick[i]         = r_tick;
    end

endmodule
`default_nettype wire
